lcm_unit: RTL and testbench
===========================

// Module: lcm_unit
// PURPOSE
//   Downstream stage of the gcd block: takes an operand pair (a, b) plus the
//   gcd result g for that pair and computes lcm(a,b) = (a / g) * b.
//   Multicycle: restoring divide (WIDTH cycles), then shift-add multiply
//   (WIDTH cycles). Valid/ready handshake on input and output.
//   Flags pairs where g cannot be a valid gcd.
// PARAMETERS
//   WIDTH   8   operand width of a, b, g; result is 2*WIDTH bits
// PORTS
//   clk        in   1          system clock, all state on rising edge
//   rst        in   1          synchronous, active-high reset
//   a          in   WIDTH      operand a (same value fed to gcd)
//   b          in   WIDTH      operand b
//   g          in   WIDTH      gcd(a,b) from gcd block output c
//   in_valid   in   1          a/b/g valid this cycle
//   in_ready   out  1          block can accept (high only in IDLE)
//   lcm        out  2*WIDTH    result; 0 when err=1
//   err        out  1          g==0 or g does not divide a
//   out_valid  out  1          lcm/err valid; held until out_ready
//   out_ready  in   1          consumer takes result
// BEHAVIOUR
//   Reset (rst=1 at clk edge): state=IDLE; lcm=0, err=0, out_valid=0,
//     in_ready=1; internal regs cleared. Reset mid-DIV/MUL/DONE aborts the
//     operation; no result emitted.
//   States: IDLE -> DIV -> MUL -> DONE -> IDLE.
//   IDLE: in_ready=1. Edge with in_valid=1: latch a, b, g; cnt=0; -> DIV.
//   DIV: one restoring-division step per edge, MSB first, dividend a,
//     divisor g; WIDTH edges, cnt counts 0..WIDTH-1; then quotient q and
//     remainder r final -> MUL. g==0: skip subtractions, set err flag.
//   MUL: product = q * b via shift-add, one bit of q per edge, WIDTH edges
//     -> DONE. Product held in 2*WIDTH-bit reg; no overflow possible.
//   DONE: out_valid=1; lcm = err ? 0 : product. err = (g==0) | (r!=0).
//     Outputs stable while out_valid=1 & out_ready=0. Edge with
//     out_ready=1: out_valid=0, -> IDLE (in_ready=1 next cycle).
//   Latency fixed: out_valid rises 2*WIDTH+1 edges after the accepting edge
//     (17 for WIDTH=8), independent of operand values, including err cases.
//   Throughput: one pair per 2*WIDTH+2 cycles minimum (accept + compute +
//     handshake).
//   in_valid while busy (in_ready=0) ignored; operands not sampled.
//   a==0 or b==0 with g!=0: lcm=0, err=0 (mathematical lcm with zero).
//   out_ready asserted outside DONE has no effect.
//   All arithmetic unsigned.
// TESTING
//   a=4,b=8,g=4 -> lcm=8, err=0, out_valid 17 edges after accept.
//   a=3,b=2,g=1 -> 6; a=6,b=14,g=2 -> 42; a=7,b=14,g=7 -> 14 (back to back).
//   a=255,b=254,g=1 -> lcm=64770 (0xFD02), err=0 (max width).
//   a=6,b=14,g=0 -> err=1, lcm=0; a=6,b=14,g=4 -> err=1, lcm=0 (r=2).
//   Hold out_ready=0 for 5 cycles in DONE -> lcm/out_valid stable,
//     in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE.
//   rst=1 during MUL of a=6,b=14,g=2 -> next cycle IDLE, out_valid=0,
//     in_ready=1; then a=3,b=2,g=1 -> lcm=6.

Source files
------------

// File: rtl/lcm_unit_if.sv
// Handshake bundle between the gcd stage, the lcm unit and its consumer.
// The master side supplies operands and takes results; the slave side is the lcm unit.
interface lcm_unit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   g;
    logic               in_valid;
    logic               in_ready;
    logic [2*WIDTH-1:0] lcm;
    logic               err;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output a, b, g, in_valid, out_ready,
        input  in_ready, lcm, err, out_valid
    );

    modport slave (
        input  a, b, g, in_valid, out_ready,
        output in_ready, lcm, err, out_valid
    );
endinterface

// File: rtl/lcm_unit.sv
// Computes lcm(a,b) = (a / g) * b from a gcd result g, using a WIDTH-cycle restoring divide
// followed by a WIDTH-cycle shift-add multiply; flags g values that cannot be the gcd of a.
module lcm_unit #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    lcm_unit_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   g_reg;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   diff;
    logic               take;
    logic               bad;

    // One restoring-division step: shift the next dividend bit into the partial remainder.
    // A zero divisor never subtracts, so the quotient stays 0 and the error path reports it.
    always_comb begin
        trial = {rem, quo[WIDTH-1]};
        diff  = trial[WIDTH-1:0] - g_reg;
        take  = (g_reg != '0) && (trial >= {1'b0, g_reg});
        bad   = (g_reg == '0) || (rem != '0);
    end

    // quo first holds the dividend and fills with quotient bits during DIV; during MUL
    // it is shifted right one quotient bit per edge. Results are registered on the first
    // DONE cycle, which places out_valid 2*WIDTH+1 edges after the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            b_reg         <= '0;
            g_reg         <= '0;
            rem           <= '0;
            quo           <= '0;
            mcand         <= '0;
            prod          <= '0;
            bus.lcm       <= '0;
            bus.err       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        quo          <= bus.a;
                        b_reg        <= bus.b;
                        g_reg        <= bus.g;
                        rem          <= '0;
                        cnt          <= '0;
                        bus.in_ready <= 1'b0;
                        state        <= DIV;
                    end
                end
                DIV: begin
                    rem <= take ? diff : trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], take};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt   <= '0;
                        prod  <= '0;
                        mcand <= {{WIDTH{1'b0}}, b_reg};
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (quo[0]) begin
                        prod <= prod + mcand;
                    end
                    mcand <= mcand << 1;
                    quo   <= quo >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt   <= '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.out_valid) begin
                        bus.out_valid <= 1'b1;
                        bus.err       <= bad;
                        bus.lcm       <= bad ? '0 : prod;
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcm_unit.sv
// Self-checking bench for lcm_unit: directed vector table, hold/reset corner cases,
// and random operand pairs checked against an arithmetic lcm model.
module tb_lcm_unit;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;

    lcm_unit_if #(.WIDTH(WIDTH)) bus ();

    lcm_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  g;
        logic [15:0] lcm;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int gcd_ref(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic lcm_model(input int a, input int b, input int g, output int lcm, output int err);
        if (g == 0 || (a % g) != 0) begin
            err = 1;
            lcm = 0;
        end else begin
            err = 0;
            lcm = (a / g) * b;
        end
    endtask

    // Wait (bounded) for in_ready, then present one operand set for a single accepting edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] g);
        int waited = 0;
        while (!bus.in_ready && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("accept_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.g        = g;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Count edges from the accepting edge until out_valid, check the result, optionally consume it.
    task automatic checkOutput(input string name, input logic [15:0] exp_lcm, input logic exp_err,
                               input bit consume);
        int lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.out_valid && lat < 60);
        check({name, "_latency"}, lat, 32'd17);
        check({name, "_lcm"}, {16'd0, bus.lcm}, {16'd0, exp_lcm});
        check({name, "_err"}, {31'd0, bus.err}, {31'd0, exp_err});
        if (consume) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            check({name, "_valid_dropped"}, {31'd0, bus.out_valid}, 32'd0);
            check({name, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
        end
    endtask

    initial begin
        int exp_lcm;
        int exp_err;
        int seen;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] rg;

        bus.a         = '0;
        bus.b         = '0;
        bus.g         = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_lcm", {16'd0, bus.lcm}, 32'd0);
        check("reset_err", {31'd0, bus.err}, 32'd0);
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst = 1'b0;

        vecs[0] = '{8'd4,   8'd8,   8'd4, 16'd8,     1'b0};
        vecs[1] = '{8'd3,   8'd2,   8'd1, 16'd6,     1'b0};
        vecs[2] = '{8'd6,   8'd14,  8'd2, 16'd42,    1'b0};
        vecs[3] = '{8'd7,   8'd14,  8'd7, 16'd14,    1'b0};
        vecs[4] = '{8'd255, 8'd254, 8'd1, 16'hFD02,  1'b0};
        vecs[5] = '{8'd6,   8'd14,  8'd0, 16'd0,     1'b1};
        vecs[6] = '{8'd6,   8'd14,  8'd4, 16'd0,     1'b1};
        vecs[7] = '{8'd0,   8'd5,   8'd5, 16'd0,     1'b0};
        vecs[8] = '{8'd9,   8'd0,   8'd9, 16'd0,     1'b0};
        vecs[9] = '{8'd12,  8'd18,  8'd6, 16'd36,    1'b0};

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].g);
            checkOutput($sformatf("vec%0d", i), vecs[i].lcm, vecs[i].err, 1'b1);
        end

        // Back-pressure: result must hold steady and new operands must be ignored.
        applyStimulus(8'd6, 8'd14, 8'd2);
        checkOutput("hold", 16'd42, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.a        = 8'd99;
            bus.b        = 8'd77;
            bus.g        = 8'd3;
            bus.in_valid = (i % 2) == 0;
            @(posedge clk);
            #1;
            check("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("hold_lcm", {16'd0, bus.lcm}, 32'd42);
            check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("hold_release_valid", {31'd0, bus.out_valid}, 32'd0);
        check("hold_release_ready", {31'd0, bus.in_ready}, 32'd1);
        applyStimulus(8'd3, 8'd2, 8'd1);
        checkOutput("after_hold", 16'd6, 1'b0, 1'b1);

        // Reset in the middle of the multiply phase aborts without emitting a result.
        applyStimulus(8'd6, 8'd14, 8'd2);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midreset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("midreset_no_result", seen, 32'd0);
        applyStimulus(8'd3, 8'd2, 8'd1);
        checkOutput("after_reset", 16'd6, 1'b0, 1'b1);

        // Random pairs: mostly a true gcd, sometimes an arbitrary (possibly invalid) g.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                rg = 8'(gcd_ref(int'(ra), int'(rb)));
            end else begin
                rg = 8'($urandom_range(0, 255));
            end
            lcm_model(int'(ra), int'(rb), int'(rg), exp_lcm, exp_err);
            applyStimulus(ra, rb, rg);
            checkOutput($sformatf("rand%0d", i), 16'(exp_lcm), exp_err[0], 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
